// File: rtl/exec_controller.sv
// Instruction sequencer for the stack processor: fetch/decode/exec with depth-tracking traps.
// Latency: 2 cycles per instruction (FETCH presents PC to ROM, EXEC fires strobes).
// Backpressure: none; strobes are single-cycle pulses in EXEC, HALT/FAULT are terminal until rst.
module exec_controller #(
    parameter int OPCODE_WIDTH = 15,
    parameter int PC_WIDTH     = 9,
    parameter int STACK_WIDTH  = 255,
    parameter int STACK_DEPTH  = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [OPCODE_WIDTH:0]  rom_data,
    input  logic [STACK_WIDTH:0]   top0,
    input  logic [STACK_WIDTH:0]   top1,
    output logic                   pc_load_sig,
    output logic                   pc_inc_sig,
    output logic [PC_WIDTH:0]      pc_load_val,
    output logic                   stack_push_sig,
    output logic [STACK_WIDTH:0]   stack_push_data,
    output logic [2:0]             stack_pop_sig,
    output logic [7:0]             depth,
    output logic                   halted,
    output logic                   fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [8:0] DEPTH_MAX = 9'(STACK_DEPTH + 1);

    state_t     state_q, state_d;
    logic [7:0] depth_q, depth_d;

    logic [3:0]             op;
    logic [2:0]             op_pops;
    logic                   op_push;
    logic [STACK_WIDTH:0]   op_data;
    logic                   op_inc;
    logic                   op_load;
    logic                   op_illegal;
    logic                   op_needs_top;
    logic                   op_halt;
    logic                   underflow;
    logic                   overflow;
    logic                   trap;
    logic [8:0]             depth_after;

    assign op = rom_data[OPCODE_WIDTH -: 4];

    // Decode the opcode into pop/push counts, PC action and push data.
    always_comb begin
        op_pops      = 3'd0;
        op_push      = 1'b0;
        op_data      = '0;
        op_inc       = 1'b0;
        op_load      = 1'b0;
        op_illegal   = 1'b0;
        op_needs_top = 1'b0;
        op_halt      = 1'b0;
        unique case (op)
            4'h0: op_inc = 1'b1;
            4'h1: begin
                op_push       = 1'b1;
                op_data[11:0] = rom_data[11:0];
                op_inc        = 1'b1;
            end
            4'h2: begin
                op_pops = 3'd1;
                op_inc  = 1'b1;
            end
            4'h3: begin
                op_push      = 1'b1;
                op_data      = top0;
                op_needs_top = 1'b1;
                op_inc       = 1'b1;
            end
            4'h4: begin
                op_pops = 3'd2;
                op_push = 1'b1;
                op_data = top0 + top1;
                op_inc  = 1'b1;
            end
            4'h5: begin
                op_pops = 3'd2;
                op_push = 1'b1;
                op_data = top0 - top1;
                op_inc  = 1'b1;
            end
            4'h6: op_load = 1'b1;
            4'h7: begin
                op_pops = 3'd1;
                op_load = (top0 == '0);
                op_inc  = (top0 != '0);
            end
            4'hF: op_halt = 1'b1;
            default: op_illegal = 1'b1;
        endcase
    end

    // Trap evaluation: pops apply before the push, so overflow uses the net depth.
    always_comb begin
        depth_after = {1'b0, depth_q} - {6'd0, op_pops} + {8'd0, op_push};
        underflow   = ({5'd0, op_pops} > depth_q) || (op_needs_top && (depth_q == 8'd0));
        overflow    = depth_after > DEPTH_MAX;
        trap        = op_illegal || underflow || overflow;
    end

    // Next state, depth update and strobes; all strobes stay low outside a clean EXEC.
    always_comb begin
        state_d         = state_q;
        depth_d         = depth_q;
        pc_load_sig     = 1'b0;
        pc_inc_sig      = 1'b0;
        pc_load_val     = '0;
        stack_push_sig  = 1'b0;
        stack_push_data = '0;
        stack_pop_sig   = 3'd0;
        unique case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (trap) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_load_sig     = op_load;
                    pc_inc_sig      = op_inc;
                    pc_load_val     = op_load ? rom_data[PC_WIDTH:0] : '0;
                    stack_push_sig  = op_push;
                    stack_push_data = op_push ? op_data : '0;
                    stack_pop_sig   = op_pops;
                    depth_d         = depth_after[7:0];
                    state_d         = op_halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and depth registers; reset clears everything including the sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            depth_q <= 8'd0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    assign depth  = depth_q;
    assign halted = (state_q == ST_HALT);
    assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: models PC, synchronous ROM and stack around the DUT.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: not applicable; directed programs with hand-computed expectations.
module tb_exec_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic [15:0]  rom_data;
    logic [255:0] top0, top1;
    logic         pc_load_sig, pc_inc_sig;
    logic [9:0]   pc_load_val;
    logic         stack_push_sig;
    logic [255:0] stack_push_data;
    logic [2:0]   stack_pop_sig;
    logic [7:0]   depth;
    logic         halted, fault;

    int tests_run = 0;
    int tests_failed = 0;
    int inc_cnt = 0;
    int push_cnt = 0;
    int both_cnt = 0;

    logic [15:0]  mem [0:1023];
    logic [9:0]   pc;
    logic [255:0] stk [0:131];

    exec_controller dut (
        .clk(clk), .rst(rst), .run(run), .rom_data(rom_data),
        .top0(top0), .top1(top1),
        .pc_load_sig(pc_load_sig), .pc_inc_sig(pc_inc_sig), .pc_load_val(pc_load_val),
        .stack_push_sig(stack_push_sig), .stack_push_data(stack_push_data),
        .stack_pop_sig(stack_pop_sig), .depth(depth), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Program counter and synchronous ROM.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= 10'd0;
            rom_data <= 16'd0;
        end else begin
            rom_data <= mem[pc];
            if (pc_load_sig)     pc <= pc_load_val;
            else if (pc_inc_sig) pc <= pc + 10'd1;
        end
    end

    // Stack: pops first, then push.
    always @(posedge clk or posedge rst) begin
        logic [255:0] tmp [0:131];
        if (rst) begin
            for (int i = 0; i < 132; i++) stk[i] <= '0;
        end else begin
            for (int i = 0; i < 132; i++) tmp[i] = stk[i];
            for (int n = 0; n < int'(stack_pop_sig); n++) begin
                for (int i = 0; i < 131; i++) tmp[i] = tmp[i+1];
                tmp[131] = '0;
            end
            if (stack_push_sig) begin
                for (int i = 131; i > 0; i--) tmp[i] = tmp[i-1];
                tmp[0] = stack_push_data;
            end
            for (int i = 0; i < 132; i++) stk[i] <= tmp[i];
        end
    end

    assign top0 = stk[0];
    assign top1 = stk[1];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (pc_inc_sig) inc_cnt++;
        if (stack_push_sig) push_cnt++;
        if (pc_inc_sig && pc_load_sig) both_cnt++;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        inc_cnt = 0;
        push_cnt = 0;
        both_cnt = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    // Pulse run for one rising edge; returns at the negedge in FETCH.
    task automatic start();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic run_until_stop(input string tag, input int budget);
        int n = 0;
        while (!halted && !fault && n < budget) begin
            step();
            n++;
        end
        chk(tag, (halted || fault), 1'b1);
    endtask

    function automatic logic [255:0] strobes();
        return {245'd0, pc_load_sig, pc_inc_sig, stack_push_sig, stack_pop_sig};
    endfunction

    initial begin
        clear_mem();

        // PUSHI 5; PUSHI 7; ADD; HALT
        mem[0] = 16'h1005; mem[1] = 16'h1007; mem[2] = 16'h4000; mem[3] = 16'hF000;
        do_reset();
        @(negedge clk);
        chk("rst_strobes", strobes(), '0);
        chk("rst_depth", depth, 8'd0);
        chk("rst_flags", {halted, fault}, 2'b00);
        chk("rst_vals", {pc_load_val, stack_push_data}, '0);
        start();
        chk("fetch_quiet", strobes(), '0);
        step();
        chk("pushi5_data", stack_push_data, 256'd5);
        chk("pushi5_strobes", strobes(), {245'd0, 1'b0, 1'b1, 1'b1, 3'd0});
        step(); step();
        chk("pushi7_data", stack_push_data, 256'd7);
        step(); step();
        chk("add_pop", stack_pop_sig, 3'd2);
        chk("add_data", stack_push_data, 256'd12);
        step(); step();
        chk("halt_exec_quiet", strobes(), '0);
        chk("halt_not_yet", halted, 1'b0);
        step();
        chk("halted", halted, 1'b1);
        chk("add_depth", depth, 8'd1);
        chk("inc_pulses", inc_cnt, 3);
        chk("no_both", both_cnt, 0);

        // PUSHI 0; JZ 0x010; [0x010] HALT
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h7010; mem[16] = 16'hF000;
        do_reset();
        start();
        step(); step(); step();
        chk("jz_strobes", strobes(), {245'd0, 1'b1, 1'b0, 1'b0, 3'd1});
        chk("jz_target", pc_load_val, 10'h010);
        run_until_stop("jz_timeout", 20);
        chk("jz_halted", {halted, fault}, 2'b10);
        chk("jz_depth", depth, 8'd0);

        // POP on empty stack
        clear_mem();
        mem[0] = 16'h2000;
        do_reset();
        start();
        step();
        chk("uf_quiet", strobes(), '0);
        step();
        chk("uf_fault", {halted, fault}, 2'b01);
        chk("uf_depth", depth, 8'd0);
        start();
        step(); step();
        chk("uf_run_ignored", {strobes(), halted, fault, depth}, {256'd0, 2'b01, 8'd0});

        // 128 x PUSHI 1 then DUP
        clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h1001;
        mem[128] = 16'h3000;
        do_reset();
        start();
        run_until_stop("of_timeout", 600);
        chk("of_fault", fault, 1'b1);
        chk("of_depth", depth, 8'd128);
        chk("of_push_cnt", push_cnt, 128);

        // PUSHI 1; PUSHI 0; SUB; HALT -> 0 - 1 wraps to all ones
        clear_mem();
        mem[0] = 16'h1001; mem[1] = 16'h1000; mem[2] = 16'h5000; mem[3] = 16'hF000;
        do_reset();
        start();
        repeat (5) step();
        chk("sub_data", stack_push_data, {256{1'b1}});
        chk("sub_pop", stack_pop_sig, 3'd2);
        run_until_stop("sub_timeout", 20);
        chk("sub_depth", depth, 8'd1);

        // Reset during EXEC of ADD
        clear_mem();
        mem[0] = 16'h1005; mem[1] = 16'h1007; mem[2] = 16'h4000; mem[3] = 16'hF000;
        do_reset();
        start();
        repeat (5) step();
        chk("pre_rst_add", stack_pop_sig, 3'd2);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {strobes(), stack_push_data, pc_load_val}, '0);
        chk("rst_mid_depth", depth, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step(); step();
        chk("idle_after_rst", {strobes(), halted, fault, depth}, '0);
        start();
        step();
        chk("restart_data", stack_push_data, 256'd5);
        chk("restart_push", stack_push_sig, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
# exec_controller

Instruction sequencer for the stack processor. It fetches 16-bit opcodes from the synchronous ROM at the current program counter and decodes them. It drives the program-counter load/increment strobes and the stack push/pop strobes. It tracks stack depth to trap underflow/overflow, and stops on HALT or fault. It sits between `ProgramCounter`, `ROM` and `STACK` in `Processor`, replacing the undriven control wires.

## Interface
- OPCODE_WIDTH, 15, msb index of opcode word (16 bits)
- PC_WIDTH, 9, msb index of program counter (10 bits)
- STACK_WIDTH, 255, msb index of stack word (256 bits)
- STACK_DEPTH, 127, msb index of stack entries (128 entries)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  start request, sampled in IDLE only
- rom_data  in  OPCODE_WIDTH+1  opcode from ROM; valid the cycle after pc is presented
- top0  in  STACK_WIDTH+1  stack preview[0] (top of stack)
- top1  in  STACK_WIDTH+1  stack preview[1] (second entry)
- pc_load_sig  out  1  load pc_load_val into PC
- pc_inc_sig  out  1  increment PC
- pc_load_val  out  PC_WIDTH+1  jump target
- stack_push_sig  out  1  push stack_push_data
- stack_push_data  out  STACK_WIDTH+1  data to push
- stack_pop_sig  out  3  number of entries to pop (0-7)
- depth  out  8  current stack occupancy, 0..128
- halted  out  1  sticky: HALT executed
- fault  out  1  sticky: underflow, overflow or illegal opcode

## Operation
- States: IDLE, FETCH, EXEC, HALT, FAULT; encoding is free.
- IDLE -> FETCH when run=1. FETCH -> EXEC unconditionally. EXEC -> FETCH normally, -> HALT on HALT, -> FAULT on a trap. HALT and FAULT are terminal until rst.
- Decode uses rom_data[15:12], with operand imm = rom_data[11:0].
  - 0 NOP: increment PC only.
  - 1 PUSHI: push {244'b0, imm}.
  - 2 POP: pop 1.
  - 3 DUP: push top0; requires depth≥1.
  - 4 ADD: pop 2, push top0+top1 mod 2^256.
  - 5 SUB: pop 2, push top0−top1 mod 2^256.
  - 6 JMP: pc_load_val = imm[9:0]; load, no increment.
  - 7 JZ: pop 1; if top0==0, load imm[9:0], else increment.
  - F HALT: no strobes.
  - Any other code: illegal, fault.
- Stack semantics for simultaneous pop and push (ADD/SUB): pops apply first, then the push. This yields net depth −1.
- Traps are evaluated in EXEC before any strobe is issued:
  - underflow: depth < required pops, or DUP with depth 0;
  - overflow: depth − pops + push > 128.
- On a trap, no strobe is asserted and the state moves to FAULT.
- depth updates on the EXEC clock edge: depth ← depth − pops + push. It is unchanged on a trap.
- pc_load_sig and pc_inc_sig are never both 1. Every non-halting, non-faulting EXEC asserts exactly one of them.
- PC wrap from 1023 to 0 is the PC's responsibility; the controller does not check it.

## Timing
- Reset values: state IDLE, depth 0, halted 0, fault 0. All strobes are 0, pc_load_val 0 and stack_push_data 0.
- All strobes are combinational from state plus rom_data/top0/top1. They are asserted only during EXEC, for exactly one cycle.
- Each instruction takes 2 cycles: in FETCH, the PC address is latched by the ROM; in EXEC, rom_data is valid and the strobes fire.
- After a jump or increment, the next FETCH presents the updated PC.
- Outputs are 0 in IDLE, FETCH, HALT and FAULT. halted is 1 in HALT and fault is 1 in FAULT, from the cycle after the causing EXEC.
- run is ignored outside IDLE.
- rst asserted mid-instruction immediately clears all state and outputs, including sticky flags. Execution restarts only after a new run.

## Test plan
- Reset then run=1, program PUSHI 5; PUSHI 7; ADD; HALT -> push 5, push 7, then pop_sig=2 with push_data=12; depth 1; halted=1 after cycle 8 post-run; pc_inc pulses 3 times.
- Program PUSHI 0; JZ 0x010; with 0x010 holding HALT -> JZ cycle asserts pop_sig=1, pc_load_sig=1, pc_load_val=0x010 and pc_inc_sig=0; then halted=1 with depth 0.
- POP with depth 0 -> no strobes, fault=1, depth stays 0; later run pulses are ignored.
- 128× PUSHI 1 then DUP -> depth 128 after the pushes; DUP faults with no push strobe.
- SUB with top0=0, top1=1 -> push_data = 2^256−1 (all ones).
- rst asserted during EXEC of ADD -> strobes drop to 0 immediately; depth 0, state IDLE; after a new run, fetch restarts at the PC reset value.
